// File: rtl/fp_align_shifter.sv
// fp_align_shifter
//   Iterative right-shift alignment for the far path of the dual-path FP adder.
//   The smaller operand's mantissa is shifted right by the exponent difference.
//   The shift advances at most STEP bits per clock. Bits shifted out land in a
//   dummy-bit field (guard, round, ..., sticky) laid out for the rounding stage.
//   Bit 0 of that field accumulates the OR of every bit that passes below it.
//
// Ports
//   clk              in   rising-edge clock
//   rst              in   synchronous, active-high reset
//   start            in   request; only looked at while idle
//   mantissa_in      in   [SIZE_MOST_S_MANTISSA]  mantissa to align
//   shift_amount     in   [SIZE_SHIFT]            right-shift distance
//   busy             out  high whenever the engine is not idle
//   done             out  one-cycle pulse; results valid and held until next start
//   aligned_mantissa out  [SIZE_MOST_S_MANTISSA]  mantissa after the shift
//   dummy_bits       out  [SIZE_LEAST_S_MANTISSA] shifted-out bits, MSB first; bit 0 sticky
//
// Build option
//   ALIGN_EARLY_SATURATE_EN  when defined, a shift >= the working width finishes
//                            in one cycle with the saturated result. Numeric results
//                            do not change.

module fp_align_shifter #(
  parameter int unsigned SIZE_MOST_S_MANTISSA  = 24,
  parameter int unsigned SIZE_LEAST_S_MANTISSA = 25,
  parameter int unsigned SIZE_SHIFT            = 8,
  parameter int unsigned STEP                  = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [SIZE_MOST_S_MANTISSA-1:0]  mantissa_in,
  input  logic [SIZE_SHIFT-1:0]            shift_amount,
  output logic                             busy,
  output logic                             done,
  output logic [SIZE_MOST_S_MANTISSA-1:0]  aligned_mantissa,
  output logic [SIZE_LEAST_S_MANTISSA-1:0] dummy_bits
);

  localparam int unsigned N = SIZE_MOST_S_MANTISSA + SIZE_LEAST_S_MANTISSA;

  localparam logic [SIZE_SHIFT-1:0]            STEP_W = SIZE_SHIFT'(STEP);
  localparam logic [N-1:0]                     ONES_N = '1;
  localparam logic [SIZE_LEAST_S_MANTISSA-1:0] ZERO_L = '0;
  localparam logic [N-2:0]                     ZERO_N1 = '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t                r_state;
  logic [N-1:0]          r_work;
  logic [SIZE_SHIFT-1:0] r_rem;
  logic                  r_busy;
  logic                  r_done;

  logic [SIZE_SHIFT-1:0] w_k;
  logic [N-1:0]          w_mask;
  logic [N-1:0]          w_shifted;
  logic [N-1:0]          w_next;
  logic                  w_last;
  logic                  w_sat;

  // One shift step of k = min(rem, STEP) bits. Every bit that falls off the
  // bottom is folded into the new bit 0 so that the sticky stays exact.
  always_comb begin
    w_k       = (r_rem > STEP_W) ? STEP_W : r_rem;
    w_mask    = ~(ONES_N << w_k);
    w_shifted = r_work >> w_k;
    w_next    = {w_shifted[N-1:1], w_shifted[0] | (|(r_work & w_mask))};
    w_last    = (r_rem == w_k);
  end

  always_comb begin
`ifdef ALIGN_EARLY_SATURATE_EN
    w_sat = (32'(shift_amount) >= N);
`else
    w_sat = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_work  <= '0;
      r_rem   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_busy <= 1'b1;
            if (w_sat) begin
              // Everything ends up below bit 0, so only the sticky survives.
              r_work  <= {ZERO_N1, |mantissa_in};
              r_rem   <= '0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_work <= {mantissa_in, ZERO_L};
              r_rem  <= shift_amount;
              if (shift_amount == '0) begin
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end else begin
                r_state <= S_SHIFT;
              end
            end
          end
        end
        S_SHIFT: begin
          r_work <= w_next;
          r_rem  <= r_rem - w_k;
          if (w_last) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy             = r_busy;
  assign done             = r_done;
  assign aligned_mantissa = r_work[N-1:SIZE_LEAST_S_MANTISSA];
  assign dummy_bits       = r_work[SIZE_LEAST_S_MANTISSA-1:0];

endmodule
